// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for the shared single-port program/data BRAM.
// Port A has priority; a starvation counter guarantees port B a slot.
module ram_port_arbiter #(
   parameter int unsigned ADDR_W       = 12,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              ram_wren,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   input  logic [DATA_W-1:0] ram_q
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             a_rvalid_q, a_rvalid_d;
   logic             b_rvalid_q, b_rvalid_d;
   logic             owner_q, owner_d;   // 1: port B owns the next ram_q

   // Grant is gated by reset so nothing reaches the RAM while rst_n is low.
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      if (rst_n) begin
         if (a_req && b_req) begin
            if (starve_cnt_q == LIMIT) b_gnt = 1'b1;
            else                       a_gnt = 1'b1;
         end else begin
            a_gnt = a_req;
            b_gnt = b_req;
         end
      end
   end

   always_comb begin
      ram_address = b_gnt ? b_addr  : a_addr;
      ram_data    = b_gnt ? b_wdata : a_wdata;
      ram_wren    = (a_gnt & a_we) | (b_gnt & b_we);
   end

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      a_rvalid_d   = a_gnt & ~a_we;
      b_rvalid_d   = b_gnt & ~b_we;
      owner_d      = owner_q;
      if (b_gnt || !b_req) begin
         starve_cnt_d = '0;
      end else if (a_gnt && (starve_cnt_q != LIMIT)) begin
         starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
      if (a_rvalid_d)      owner_d = 1'b0;
      else if (b_rvalid_d) owner_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q <= '0;
         a_rvalid_q   <= 1'b0;
         b_rvalid_q   <= 1'b0;
         owner_q      <= 1'b0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
         a_rvalid_q   <= a_rvalid_d;
         b_rvalid_q   <= b_rvalid_d;
         owner_q      <= owner_d;
      end
   end

   assign a_rvalid = a_rvalid_q;
   assign b_rvalid = b_rvalid_q;
   assign a_rdata  = owner_q ? '0 : ram_q;
   assign b_rdata  = owner_q ? ram_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus randomized traffic
// checked against a grant-rule/memory reference model.
module tb_ram_port_arbiter;

   localparam int LIMIT = 4;

   logic        clk, rst_n;
   logic        a_req, a_we, b_req, b_we;
   logic [11:0] a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [15:0] a_rdata, b_rdata;
   logic        ram_wren;
   logic [11:0] ram_address;
   logic [15:0] ram_data, ram_q;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural single-port RAM with a bench-only preload port
   logic [15:0] ram_mem [4096];
   logic        pre_we = 1'b0;
   logic [11:0] pre_addr = '0;
   logic [15:0] pre_data = '0;

   // Reference model memory for randomized traffic
   logic [15:0] m_mem [4096];

   ram_port_arbiter #(.ADDR_W(12), .DATA_W(16), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .ram_wren(ram_wren), .ram_address(ram_address), .ram_data(ram_data),
      .ram_q(ram_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we)        ram_mem[pre_addr] <= pre_data;
      else if (ram_wren) ram_mem[ram_address] <= ram_data;
      else               ram_q <= ram_mem[ram_address];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic set_a(input logic req, input logic we, input logic [11:0] addr, input logic [15:0] data);
      a_req = req; a_we = we; a_addr = addr; a_wdata = data;
   endtask

   task automatic set_b(input logic req, input logic we, input logic [11:0] addr, input logic [15:0] data);
      b_req = req; b_we = we; b_addr = addr; b_wdata = data;
   endtask

   task automatic preload(input logic [11:0] addr, input logic [15:0] data);
      @(negedge clk);
      pre_addr = addr; pre_data = data; pre_we = 1'b1;
      m_mem[addr] = data;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_a(1'b1, 1'b1, 12'h000, 16'hFFFF);
      set_b(1'b1, 1'b1, 12'h007, 16'h1234);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         n_vec++;
         if ({a_gnt, b_gnt, ram_wren, a_rvalid, b_rvalid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_quiet: got gnt/wren/rv=%b expected 00000",
                     {a_gnt, b_gnt, ram_wren, a_rvalid, b_rvalid});
         end
      end
      preload(12'h000, 16'h8020);
      @(negedge clk);
      set_b(1'b0, 1'b0, 12'h000, 16'h0000);
      set_a(1'b1, 1'b0, 12'h000, 16'h0000);
      rst_n = 1'b1;
      #1;
      n_vec++;
      if ({a_gnt, b_gnt} !== 2'b10) begin
         n_err++; $display("FAIL first_grant: got %b expected 10", {a_gnt, b_gnt});
      end
      @(negedge clk);
      set_a(1'b0, 1'b0, 12'h000, 16'h0000);
      #1;
      n_vec++;
      if ({a_rvalid, b_rvalid} !== 2'b10) begin
         n_err++; $display("FAIL first_rvalid: got %b expected 10", {a_rvalid, b_rvalid});
      end
      n_vec++;
      if (a_rdata !== 16'h8020) begin
         n_err++; $display("FAIL first_rdata: got %h expected 8020", a_rdata);
      end
      @(negedge clk); #1;
      n_vec++;
      if ({a_rvalid, b_rvalid} !== 2'b00) begin
         n_err++; $display("FAIL rvalid_one_cycle: got %b expected 00", {a_rvalid, b_rvalid});
      end
   endtask

   task automatic test_contention();
      logic [9:0] pat;
      logic [1:0] exp_g, prev_g;
      pat = 10'b10_0001_0000;   // bit i set: B wins slot i
      prev_g = 2'b00;
      for (int i = 0; i <= 10; i++) begin
         @(negedge clk);
         if (i < 10) begin
            set_a(1'b1, 1'b0, 12'h040, 16'h0000);
            set_b(1'b1, 1'b0, 12'h041, 16'h0000);
         end else begin
            set_a(1'b0, 1'b0, 12'h000, 16'h0000);
            set_b(1'b0, 1'b0, 12'h000, 16'h0000);
         end
         #1;
         exp_g = (i < 10) ? (pat[i] ? 2'b01 : 2'b10) : 2'b00;
         n_vec++;
         if ({a_gnt, b_gnt} !== exp_g) begin
            n_err++; $display("FAIL contention_gnt[%0d]: got %b expected %b", i, {a_gnt, b_gnt}, exp_g);
         end
         n_vec++;
         if ({a_rvalid, b_rvalid} !== prev_g) begin
            n_err++; $display("FAIL contention_rv[%0d]: got %b expected %b", i, {a_rvalid, b_rvalid}, prev_g);
         end
         prev_g = exp_g;
      end
   endtask

   task automatic test_b_write_a_read();
      @(negedge clk);
      set_b(1'b1, 1'b1, 12'h005, 16'hC0D0);
      #1;
      n_vec++;
      if ({a_gnt, b_gnt, ram_wren} !== 3'b011) begin
         n_err++; $display("FAIL bwr_gnt: got %b expected 011", {a_gnt, b_gnt, ram_wren});
      end
      n_vec++;
      if ({ram_address, ram_data} !== {12'h005, 16'hC0D0}) begin
         n_err++; $display("FAIL bwr_bus: got %h/%h expected 005/c0d0", ram_address, ram_data);
      end
      @(negedge clk);
      set_b(1'b0, 1'b0, 12'h000, 16'h0000);
      set_a(1'b1, 1'b0, 12'h005, 16'h0000);
      #1;
      n_vec++;
      if ({a_gnt, b_gnt, ram_wren, a_rvalid, b_rvalid} !== 5'b10000) begin
         n_err++; $display("FAIL raw_gnt: got %b expected 10000",
                           {a_gnt, b_gnt, ram_wren, a_rvalid, b_rvalid});
      end
      @(negedge clk);
      set_a(1'b0, 1'b0, 12'h000, 16'h0000);
      #1;
      n_vec++;
      if ({a_rvalid, b_rvalid, ram_wren} !== 3'b100) begin
         n_err++; $display("FAIL raw_rv: got %b expected 100", {a_rvalid, b_rvalid, ram_wren});
      end
      n_vec++;
      if (a_rdata !== 16'hC0D0) begin
         n_err++; $display("FAIL raw_rdata: got %h expected c0d0", a_rdata);
      end
   endtask

   task automatic test_interleave();
      logic [15:0] wd;
      wd = 16'($urandom);
      preload(12'h001, 16'h8103);
      @(negedge clk);
      set_a(1'b1, 1'b0, 12'h001, 16'h0000);
      #1;
      n_vec++;
      if (a_gnt !== 1'b1) begin
         n_err++; $display("FAIL ilv_agnt: got %b expected 1", a_gnt);
      end
      @(negedge clk);
      set_a(1'b0, 1'b0, 12'h000, 16'h0000);
      set_b(1'b1, 1'b1, 12'h001, wd);
      #1;
      n_vec++;
      if ({b_gnt, ram_wren, a_rvalid} !== 3'b111) begin
         n_err++; $display("FAIL ilv_bwr: got %b expected 111", {b_gnt, ram_wren, a_rvalid});
      end
      n_vec++;
      if (a_rdata !== 16'h8103) begin
         n_err++; $display("FAIL ilv_old_data: got %h expected 8103", a_rdata);
      end
      @(negedge clk);
      set_b(1'b0, 1'b0, 12'h000, 16'h0000);
      set_a(1'b1, 1'b0, 12'h001, 16'h0000);
      #1;
      n_vec++;
      if ({a_rvalid, b_rvalid} !== 2'b00) begin
         n_err++; $display("FAIL ilv_no_wr_rv: got %b expected 00", {a_rvalid, b_rvalid});
      end
      @(negedge clk);
      set_a(1'b0, 1'b0, 12'h000, 16'h0000);
      #1;
      n_vec++;
      if (a_rvalid !== 1'b1 || a_rdata !== wd) begin
         n_err++; $display("FAIL ilv_new_data: got %b/%h expected 1/%h", a_rvalid, a_rdata, wd);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] exp_g, prev_g;
      preload(12'h020, 16'h0BAD);
      @(negedge clk);
      set_a(1'b1, 1'b0, 12'h010, 16'h0000);
      set_b(1'b1, 1'b1, 12'h020, 16'hDEAD);
      // Three A grants raise the starvation count; the fourth is cut by reset.
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         n_vec++;
         if ({a_gnt, b_gnt} !== 2'b10) begin
            n_err++; $display("FAIL mid_build[%0d]: got %b expected 10", k, {a_gnt, b_gnt});
         end
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if ({a_gnt, b_gnt, ram_wren, a_rvalid} !== 4'b0000) begin
         n_err++; $display("FAIL mid_reset_async: got %b expected 0000", {a_gnt, b_gnt, ram_wren, a_rvalid});
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); #1;
         n_vec++;
         if ({a_gnt, b_gnt, ram_wren, a_rvalid, b_rvalid} !== 5'b0) begin
            n_err++; $display("FAIL mid_reset_hold[%0d]: got %b expected 00000", k,
                              {a_gnt, b_gnt, ram_wren, a_rvalid, b_rvalid});
         end
      end
      prev_g = 2'b00;
      for (int i = 0; i <= 5; i++) begin
         @(negedge clk);
         if (i == 0) begin
            rst_n = 1'b1;
            set_b(1'b1, 1'b0, 12'h020, 16'h0000);
         end
         if (i == 5) begin
            set_a(1'b0, 1'b0, 12'h000, 16'h0000);
            set_b(1'b0, 1'b0, 12'h000, 16'h0000);
         end
         #1;
         exp_g = (i < 4) ? 2'b10 : ((i == 4) ? 2'b01 : 2'b00);
         n_vec++;
         if ({a_gnt, b_gnt} !== exp_g) begin
            n_err++; $display("FAIL mid_after_gnt[%0d]: got %b expected %b", i, {a_gnt, b_gnt}, exp_g);
         end
         n_vec++;
         if ({a_rvalid, b_rvalid} !== prev_g) begin
            n_err++; $display("FAIL mid_after_rv[%0d]: got %b expected %b", i, {a_rvalid, b_rvalid}, prev_g);
         end
         prev_g = exp_g;
      end
      n_vec++;
      if (b_rdata !== 16'h0BAD) begin
         n_err++; $display("FAIL mid_no_write: got %h expected 0bad", b_rdata);
      end
   endtask

   task automatic test_idle_edge();
      logic [15:0] wd;
      wd = 16'($urandom);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         n_vec++;
         if ({a_gnt, b_gnt, ram_wren, a_rvalid, b_rvalid} !== 5'b0) begin
            n_err++; $display("FAIL idle[%0d]: got %b expected 00000", i,
                              {a_gnt, b_gnt, ram_wren, a_rvalid, b_rvalid});
         end
      end
      @(negedge clk);
      set_b(1'b1, 1'b1, 12'hFFF, wd);
      #1;
      n_vec++;
      if ({b_gnt, ram_wren, ram_address} !== {2'b11, 12'hFFF}) begin
         n_err++; $display("FAIL edge_wr: got %b/%h expected 11/fff", {b_gnt, ram_wren}, ram_address);
      end
      @(negedge clk);
      set_b(1'b1, 1'b0, 12'hFFF, 16'h0000);
      @(negedge clk);
      set_b(0, 0, 12'h000, 16'h0000);
      set_a(1'b1, 1'b0, 12'h000, 16'h0000);
      #1;
      n_vec++;
      if (b_rvalid !== 1'b1 || b_rdata !== wd) begin
         n_err++; $display("FAIL edge_rd: got %b/%h expected 1/%h", b_rvalid, b_rdata, wd);
      end
      @(negedge clk);
      set_a(1'b0, 1'b0, 12'h000, 16'h0000);
      #1;
      n_vec++;
      if (a_rvalid !== 1'b1 || a_rdata !== 16'h8020) begin
         n_err++; $display("FAIL edge_nowrap: got %b/%h expected 1/8020", a_rvalid, a_rdata);
      end
   endtask

   task automatic test_random();
      logic        pa_req, pa_we, pb_req, pb_we, ga, gb, ex_wren;
      logic [11:0] pa_addr, pb_addr;
      logic [15:0] pa_data, pb_data, exp_rd;
      logic        exp_a_rv, exp_b_rv;
      int          m_starve;
      for (int i = 0; i < 16; i++) preload(12'h100 + 12'(i), 16'($urandom));
      pa_req = 1'b0; pa_we = 1'b0; pa_addr = '0; pa_data = '0;
      pb_req = 1'b0; pb_we = 1'b0; pb_addr = '0; pb_data = '0;
      exp_a_rv = 1'b0; exp_b_rv = 1'b0; exp_rd = '0; m_starve = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         set_a(pa_req, pa_we, pa_addr, pa_data);
         set_b(pb_req, pb_we, pb_addr, pb_data);
         #1;
         ga = pa_req && (!pb_req || m_starve < LIMIT);
         gb = pb_req && !ga;
         ex_wren = (ga && pa_we) || (gb && pb_we);
         n_vec++;
         if ({a_gnt, b_gnt, ram_wren} !== {ga, gb, ex_wren}) begin
            n_err++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, {a_gnt, b_gnt, ram_wren}, {ga, gb, ex_wren});
         end
         if (ga || gb) begin
            n_vec++;
            if (ram_address !== (ga ? pa_addr : pb_addr)) begin
               n_err++; $display("FAIL rnd_addr[%0d]: got %h expected %h", c, ram_address, ga ? pa_addr : pb_addr);
            end
         end
         if (ex_wren) begin
            n_vec++;
            if (ram_data !== (ga ? pa_data : pb_data)) begin
               n_err++; $display("FAIL rnd_wdata[%0d]: got %h expected %h", c, ram_data, ga ? pa_data : pb_data);
            end
         end
         n_vec++;
         if ({a_rvalid, b_rvalid} !== {exp_a_rv, exp_b_rv}) begin
            n_err++; $display("FAIL rnd_rv[%0d]: got %b expected %b", c, {a_rvalid, b_rvalid}, {exp_a_rv, exp_b_rv});
         end
         if (exp_a_rv || exp_b_rv) begin
            n_vec++;
            if ((exp_a_rv ? a_rdata : b_rdata) !== exp_rd) begin
               n_err++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", c,
                                 exp_a_rv ? a_rdata : b_rdata, exp_rd);
            end
         end
         exp_a_rv = ga && !pa_we;
         exp_b_rv = gb && !pb_we;
         if (exp_a_rv) exp_rd = m_mem[pa_addr];
         if (exp_b_rv) exp_rd = m_mem[pb_addr];
         if (ga && pa_we) m_mem[pa_addr] = pa_data;
         if (gb && pb_we) m_mem[pb_addr] = pb_data;
         if (gb || !pb_req)            m_starve = 0;
         else if (ga && m_starve < LIMIT) m_starve = m_starve + 1;
         if (ga || !pa_req) begin
            pa_req  = ($urandom_range(0, 3) != 0);
            pa_we   = ($urandom_range(0, 2) == 0);
            pa_addr = 12'h100 + 12'($urandom_range(0, 15));
            pa_data = 16'($urandom);
         end
         if (gb || !pb_req) begin
            pb_req  = ($urandom_range(0, 2) != 0);
            pb_we   = ($urandom_range(0, 1) == 0);
            pb_addr = 12'h100 + 12'($urandom_range(0, 15));
            pb_data = 16'($urandom);
         end
      end
      @(negedge clk);
      set_a(1'b0, 1'b0, 12'h000, 16'h0000);
      set_b(1'b0, 1'b0, 12'h000, 16'h0000);
      #1;
      n_vec++;
      if ({a_rvalid, b_rvalid} !== {exp_a_rv, exp_b_rv}) begin
         n_err++; $display("FAIL rnd_tail_rv: got %b expected %b", {a_rvalid, b_rvalid}, {exp_a_rv, exp_b_rv});
      end
   endtask

   initial begin
      rst_n = 1'b0;
      set_a(1'b0, 1'b0, 12'h000, 16'h0000);
      set_b(1'b0, 1'b0, 12'h000, 16'h0000);
      test_reset();
      test_contention();
      test_b_write_a_read();
      test_interleave();
      test_reset_mid();
      test_idle_edge();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port 16-bit x 4096-word program/data BRAM between two requesters:
  - Port A: CPU fetch/load-store, the primary port.
  - Port B: loader/debug writer, the secondary port.
- Grants at most one access per cycle, muxes address, data and write-enable onto the RAM, and returns read data with a valid strobe one cycle later.
- Port A has priority. A starvation counter guarantees port B a slot after a bounded run of A grants.

Parameters:
- ADDR_W, 12, RAM address width (4096 words).
- DATA_W, 16, RAM data width.
- STARVE_LIMIT, 4, maximum consecutive A grants while B waits. Legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A access request.
- a_we  in  1  port A write (1) / read (0).
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DATA_W  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- ram_wren  out  1  to RAM write enable.
- ram_address  out  ADDR_W  to RAM address.
- ram_data  out  DATA_W  to RAM write data.
- ram_q  in  DATA_W  from RAM registered read data.

Behaviour:
- Reset:
  - Asynchronous assertion.
  - While rst_n=0: a_gnt=b_gnt=0, ram_wren=0, a_rvalid=b_rvalid=0, starve_cnt=0.
  - Any read in flight is discarded; no rvalid after release.
  - First grant possible in the first cycle with rst_n=1.
- Handshake:
  - Requester holds req, we, addr and wdata stable until it sees gnt=1.
  - The access is consumed at the rising edge where gnt=1.
  - req may drop only after that edge.
  - gnt is combinational from req and registered state.
- Arbitration (combinational each cycle):
  - Only a_req: grant A.
  - Only b_req: grant B.
  - Neither: no grant.
  - Both, starve_cnt < STARVE_LIMIT: grant A.
  - Both, starve_cnt == STARVE_LIMIT: grant B.
- starve_cnt update at the clock edge:
  - A granted while b_req=1: increment.
  - B granted: clear.
  - b_req=0: clear.
  - Otherwise: hold.
  - Saturates at STARVE_LIMIT; never wraps.
- RAM mux:
  - A granted: ram_address=a_addr, ram_data=a_wdata, ram_wren=a_we.
  - B granted: same from the B inputs.
  - No grant: ram_wren=0, ram_address=a_addr, ram_data=a_wdata. The resulting idle read is harmless.
- Read latency:
  - The RAM registers ram_q at the grant edge.
  - A read granted in cycle N gives x_rvalid=1 in cycle N+1 for exactly one cycle, with x_rdata = ram_q.
  - Back-to-back reads give back-to-back rvalid, in grant order, on the owning port.
  - Outside rvalid, x_rdata is don't-care; benches check it only when rvalid=1.
- Writes:
  - Committed at the grant edge.
  - No rvalid is produced.
  - The RAM holds ram_q during a write cycle; a write following a read does not disturb that read's return data.
- Read-after-write, same address, consecutive cycles: the read returns the newly written data, because the write edge precedes the read edge.
- A and B never both gnt=1. a_rvalid and b_rvalid are never both 1.
- Owner tag:
  - A 1-bit registered tag records which port is owed the next ram_q.
  - The rvalid pipeline is one register per port, set by a read grant and cleared otherwise.

Test Plan:
- Reset then A read: rst_n low 3 cycles, preload mem[0]=16'h8020, a_req=1 a_we=0 a_addr=0 -> a_gnt=1 in cycle 0, a_rvalid=1 with a_rdata=16'h8020 in cycle 1, b_rvalid=0 throughout.
- Contention, STARVE_LIMIT=4: a_req and b_req held high, both reads -> grant sequence A,A,A,A,B,A,A,A,A,B. rvalid strobes follow the same sequence one cycle later.
- B write then A read: b_req=1 b_we=1 b_addr=12'h005 b_wdata=16'hC0D0 granted -> next cycle A reads 12'h005 -> a_rdata=16'hC0D0; ram_wren high only in the B grant cycle.
- Read/write interleave: A read mem[1]=16'h8103 granted, then B write to 12'h001 granted the next cycle -> a_rdata=16'h8103 in the cycle of the B write; a subsequent A read returns the new value.
- Reset mid-operation: A read granted, rst_n asserted before the next edge -> a_rvalid stays 0, starve_cnt=0, no RAM write occurs during reset.
- Idle and edge address: no requests for 10 cycles -> ram_wren=0, no gnt, no rvalid; then B write to 12'hFFF and read back -> data matches, no address wrap.
